// File: rtl/id_operand_stage.sv
// Decode/operand stage: register file with write-back bypass, ALU operand forming,
// and a one-entry valid/ready slot whose held register operands track later write-backs.
module id_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [15:0]       imm16,
    input  logic [4:0]        shamt,
    input  logic [1:0]        src2_sel,
    input  logic [3:0]        alu_ctrl_in,
    input  logic              reg_write_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [3:0]        ALU_control,
    output logic [REG_AW-1:0] dst_addr,
    output logic              reg_write_out
);

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_SEXT  = 2'b01,
        SEL_ZEXT  = 2'b10,
        SEL_SHIFT = 2'b11
    } src2_sel_e;

    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] src1_next;
    logic [DATA_W-1:0] src2_next;
    logic              accept;
    src2_sel_e         sel;

    logic [REG_AW-1:0] held_src1_addr;
    logic [REG_AW-1:0] held_rt_addr;
    logic              held_src2_is_reg;

    assign sel      = src2_sel_e'(src2_sel);
    assign in_ready = rst_n && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // regs[0] is never written and resets to zero, so it reads as zero without a mux
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_val = regs[rs_addr];
        rt_val = regs[rt_addr];
        if (wb_en && wb_addr == rs_addr && rs_addr != '0) rs_val = wb_data;
        if (wb_en && wb_addr == rt_addr && rt_addr != '0) rt_val = wb_data;
    end

    always_comb begin
        src1_next = rs_val;
        src2_next = rt_val;
        unique case (sel)
            SEL_REG:   src2_next = rt_val;
            SEL_SEXT:  src2_next = {{(DATA_W-16){imm16[15]}}, imm16};
            SEL_ZEXT:  src2_next = {{(DATA_W-16){1'b0}}, imm16};
            SEL_SHIFT: begin
                src1_next = rt_val;
                src2_next = {{(DATA_W-5){1'b0}}, shamt};
            end
            default: ;
        endcase
    end

    // Refresh branch is only reachable with out_valid && !out_ready, since consume is handled above it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            src1             <= '0;
            src2             <= '0;
            ALU_control      <= '0;
            dst_addr         <= '0;
            reg_write_out    <= 1'b0;
            held_src1_addr   <= '0;
            held_rt_addr     <= '0;
            held_src2_is_reg <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            src1             <= src1_next;
            src2             <= src2_next;
            ALU_control      <= alu_ctrl_in;
            dst_addr         <= rd_addr;
            reg_write_out    <= reg_write_in;
            held_src1_addr   <= (sel == SEL_SHIFT) ? rt_addr : rs_addr;
            held_rt_addr     <= rt_addr;
            held_src2_is_reg <= (sel == SEL_REG);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid && wb_en && wb_addr != '0) begin
            if (wb_addr == held_src1_addr) src1 <= wb_data;
            if (held_src2_is_reg && wb_addr == held_rt_addr) src2 <= wb_data;
        end
    end

endmodule
